// File: rtl/apb_regfile_completer.sv
// APB4 completer with an 8 x 32-bit register file, programmable wait states and
// pslverr on misaligned, non-secure-to-secure and read-only accesses.
//
// state  | meaning
// IDLE   | waiting for a setup phase (psel=1, penable=0)
// ACCESS | request latched, counting down wait states
// DONE   | pready pulse; write commits at the end of this cycle
module apb_regfile_completer #(
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        pwrite,
   input  logic [4:0]  addr,
   input  logic        psel,
   input  logic        penable,
   input  logic [3:0]  pstrobe,
   input  logic [2:0]  prot,
   input  logic [31:0] pwdata,
   output logic        pready,
   output logic        pslverr,
   output logic [31:0] prdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        pwrite_q, pwrite_d;
   logic [4:0]  addr_q, addr_d;
   logic [3:0]  strb_q, strb_d;
   logic        prot_ns_q, prot_ns_d;
   logic [31:0] wdata_q, wdata_d;
   logic        pready_q, pready_d;
   logic        pslverr_q, pslverr_d;
   logic [31:0] prdata_q, prdata_d;
   logic [31:0] regs_q [0:6];
   logic [31:0] regs_d [0:6];

   logic [2:0]  idx;
   logic        err_misal, err_sec, err_ro, acc_err;
   logic [31:0] rd_val;
   logic        unused_prot;

   // only prot[1] (non-secure) participates in access control
   assign unused_prot = ^{prot[2], prot[0]};

   assign idx       = addr_q[4:2];
   assign err_misal = (addr_q[1:0] != 2'b00);
   assign err_sec   = (idx == 3'd6) && prot_ns_q;
   assign err_ro    = (idx == 3'd7) && pwrite_q;
   assign acc_err   = err_misal || err_sec || err_ro;

   always_comb begin
      rd_val = 32'h0;
      if (idx == 3'd7) begin
         rd_val = ID_VALUE;
      end else begin
         rd_val = regs_q[idx];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pwrite_d  = pwrite_q;
      addr_d    = addr_q;
      strb_d    = strb_q;
      prot_ns_d = prot_ns_q;
      wdata_d   = wdata_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = 32'h0;
      regs_d    = regs_q;

      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               pwrite_d  = pwrite;
               addr_d    = addr;
               strb_d    = pstrobe;
               prot_ns_d = prot[1];
               wdata_d   = pwdata;
               cnt_d     = WAIT_INIT;
               state_d   = ACCESS;
            end
         end
         ACCESS: begin
            if (!(psel && penable)) begin
               state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               pready_d  = 1'b1;
               pslverr_d = acc_err;
               prdata_d  = (!pwrite_q && !acc_err) ? rd_val : 32'h0;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            // an errored write never reaches here with pslverr_q low, so idx is 0..6
            if (pwrite_q && !pslverr_q) begin
               for (int b = 0; b < 4; b++) begin
                  if (strb_q[b]) begin
                     regs_d[idx][8*b +: 8] = wdata_q[8*b +: 8];
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         pwrite_q  <= 1'b0;
         addr_q    <= 5'd0;
         strb_q    <= 4'd0;
         prot_ns_q <= 1'b0;
         wdata_q   <= 32'h0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= 32'h0;
         for (int i = 0; i < 7; i++) begin
            regs_q[i] <= 32'h0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pwrite_q  <= pwrite_d;
         addr_q    <= addr_d;
         strb_q    <= strb_d;
         prot_ns_q <= prot_ns_d;
         wdata_q   <= wdata_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         for (int i = 0; i < 7; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Bench for apb_regfile_completer: three instances (0, 2 and 3 wait states) on a
// shared bus; expected responses are queued at issue and checked by a monitor.
module tb_apb_regfile_completer;

   logic        clk;
   logic        resetn;
   logic        pwrite;
   logic [4:0]  addr;
   logic        penable;
   logic [3:0]  pstrobe;
   logic [2:0]  prot;
   logic [31:0] pwdata;
   logic        psel0, psel2, psel3;
   logic        pready0, pready2, pready3;
   logic        pslverr0, pslverr2, pslverr3;
   logic [31:0] prdata0, prdata2, prdata3;

   localparam logic [31:0] ID = 32'hA9B0_0001;

   apb_regfile_completer #(.WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
      .clk(clk), .resetn(resetn), .pwrite(pwrite), .addr(addr), .psel(psel0),
      .penable(penable), .pstrobe(pstrobe), .prot(prot), .pwdata(pwdata),
      .pready(pready0), .pslverr(pslverr0), .prdata(prdata0));

   apb_regfile_completer #(.WAIT_STATES(2), .ID_VALUE(ID)) dut2 (
      .clk(clk), .resetn(resetn), .pwrite(pwrite), .addr(addr), .psel(psel2),
      .penable(penable), .pstrobe(pstrobe), .prot(prot), .pwdata(pwdata),
      .pready(pready2), .pslverr(pslverr2), .prdata(prdata2));

   apb_regfile_completer #(.WAIT_STATES(3), .ID_VALUE(ID)) dut3 (
      .clk(clk), .resetn(resetn), .pwrite(pwrite), .addr(addr), .psel(psel3),
      .penable(penable), .pstrobe(pstrobe), .prot(prot), .pwdata(pwdata),
      .pready(pready3), .pslverr(pslverr3), .prdata(prdata3));

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          due;
      int          id;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          txn_id = 0;
   logic [31:0] model [0:6];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic rdy(input int inst);
      if (inst == 0) return pready0;
      if (inst == 2) return pready2;
      return pready3;
   endfunction

   task automatic bus_idle();
      psel0 = 1'b0; psel2 = 1'b0; psel3 = 1'b0; penable = 1'b0;
   endtask

   task automatic setup(input int inst, input logic wr, input logic [4:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
      pwrite = wr; addr = a; pwdata = d; pstrobe = s; prot = p; penable = 1'b0;
      psel0 = (inst == 0); psel2 = (inst == 2); psel3 = (inst == 3);
   endtask

   // Called just after a rising edge; returns just after the edge that ends DONE.
   task automatic xfer(input int inst, input logic wr, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic [2:0] p,
                       input logic [31:0] ed, input logic ee);
      exp_t e;
      bit   got;
      int   n;
      setup(inst, wr, a, d, s, p);
      e.data = ed; e.err = ee; e.id = txn_id;
      e.due  = cyc + 2 + ((inst == 0) ? 0 : inst);
      txn_id++;
      sb_q.push_back(e);
      @(posedge clk); #1;
      penable = 1'b1;
      pwdata  = ~d;
      pstrobe = ~s;
      got = 1'b0;
      n = 0;
      while (!got && n < 40) begin
         @(posedge clk); #1;
         if (rdy(inst)) got = 1'b1;
         n++;
      end
      if (!got) check("xfer_timeout", 32'(got), 32'd1);
      @(posedge clk); #1;
      bus_idle();
   endtask

   // monitor: pops the oldest expectation whenever any instance raises pready
   initial begin
      exp_t        e;
      logic [2:0]  pr;
      logic        prev_pr;
      logic [31:0] a_d;
      logic        a_e;
      prev_pr = 1'b0;
      forever begin
         @(negedge clk);
         pr = {pready3, pready2, pready0};
         if (pr != 3'b000) begin
            if (!$onehot(pr)) check("pready_onehot", 32'(pr), 32'd1);
            if (pready0) begin a_d = prdata0; a_e = pslverr0; end
            else if (pready2) begin a_d = prdata2; a_e = pslverr2; end
            else begin a_d = prdata3; a_e = pslverr3; end
            check("pready_pulse_width", 32'(prev_pr), 32'd0);
            if (sb_q.size() == 0) begin
               check("unexpected_pready", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("txn%0d_prdata", e.id), a_d, e.data);
               check($sformatf("txn%0d_pslverr", e.id), 32'(a_e), 32'(e.err));
               check($sformatf("txn%0d_latency", e.id), 32'(cyc), 32'(e.due));
            end
         end
         prev_pr = |pr;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      logic [2:0]  ridx;
      logic [31:0] rd;
      logic [3:0]  rs;
      resetn = 1'b1;
      bus_idle();
      pwrite = 1'b0; addr = 5'h0; pstrobe = 4'h0; prot = 3'b000; pwdata = 32'h0;
      #1 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_pready", 32'(pready0 | pready2 | pready3), 32'd0);
      check("reset_pslverr", 32'(pslverr0 | pslverr2 | pslverr3), 32'd0);
      check("reset_prdata", prdata0 | prdata2 | prdata3, 32'h0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // basic write / read, zero wait states
      xfer(0, 1, 5'h04, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'h0, 1'b0);
      xfer(0, 0, 5'h04, 32'h0, 4'h0, 3'b000, 32'hDEAD_BEEF, 1'b0);
      // byte strobes
      xfer(0, 1, 5'h00, 32'h1122_3344, 4'hF, 3'b000, 32'h0, 1'b0);
      xfer(0, 1, 5'h00, 32'hAABB_CCDD, 4'b0101, 3'b000, 32'h0, 1'b0);
      xfer(0, 0, 5'h00, 32'h0, 4'hF, 3'b000, 32'h11BB_33DD, 1'b0);
      xfer(0, 1, 5'h08, 32'hFFFF_FFFF, 4'h0, 3'b000, 32'h0, 1'b0);
      xfer(0, 0, 5'h08, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);
      // error responses
      xfer(0, 0, 5'h02, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1);
      xfer(0, 1, 5'h1C, 32'h1234_5678, 4'hF, 3'b000, 32'h0, 1'b1);
      xfer(0, 0, 5'h1C, 32'h0, 4'h0, 3'b000, ID, 1'b0);
      xfer(0, 0, 5'h1C, 32'h0, 4'h0, 3'b010, ID, 1'b0);
      xfer(0, 1, 5'h18, 32'hCAFE_F00D, 4'hF, 3'b000, 32'h0, 1'b0);
      xfer(0, 1, 5'h18, 32'h0000_0000, 4'hF, 3'b010, 32'h0, 1'b1);
      xfer(0, 0, 5'h18, 32'h0, 4'h0, 3'b010, 32'h0, 1'b1);
      xfer(0, 0, 5'h18, 32'h0, 4'h0, 3'b000, 32'hCAFE_F00D, 1'b0);
      xfer(0, 1, 5'h09, 32'h5555_5555, 4'hF, 3'b000, 32'h0, 1'b1);
      xfer(0, 0, 5'h08, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);
      xfer(0, 0, 5'h1F, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1);

      // three wait states: pready only at T+5
      xfer(3, 1, 5'h0C, 32'h0102_0304, 4'hF, 3'b000, 32'h0, 1'b0);
      xfer(3, 0, 5'h0C, 32'h0, 4'h0, 3'b000, 32'h0102_0304, 1'b0);

      // abort in ACCESS with two wait states
      xfer(2, 1, 5'h10, 32'h0F0F_0F0F, 4'hF, 3'b000, 32'h0, 1'b0);
      setup(2, 1, 5'h10, 32'hFFFF_FFFF, 4'hF, 3'b000);
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      bus_idle();
      repeat (6) @(posedge clk);
      #1;
      xfer(2, 0, 5'h10, 32'h0, 4'h0, 3'b000, 32'h0F0F_0F0F, 1'b0);

      // reset while a read response is on the bus
      setup(0, 0, 5'h04, 32'h0, 4'h0, 3'b000);
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      check("pre_reset_pready", 32'(pready0), 32'd1);
      check("pre_reset_prdata", prdata0, 32'hDEAD_BEEF);
      #1 resetn = 1'b0;
      #1;
      check("async_reset_pready", 32'(pready0), 32'd0);
      check("async_reset_prdata", prdata0, 32'h0);
      bus_idle();
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      // reset during ACCESS of a write
      setup(3, 1, 5'h0C, 32'h7777_7777, 4'hF, 3'b000);
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      check("access_reset_pready", 32'(pready3), 32'd0);
      check("access_reset_pslverr", 32'(pslverr3), 32'd0);
      check("access_reset_prdata", prdata3, 32'h0);
      bus_idle();
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         xfer(0, 0, 5'(i * 4), 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);
      end
      xfer(0, 0, 5'h1C, 32'h0, 4'h0, 3'b000, ID, 1'b0);
      xfer(3, 0, 5'h0C, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);
      xfer(2, 0, 5'h10, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);

      // back-to-back random write/read pairs against a byte-lane model
      for (int i = 0; i < 7; i++) model[i] = 32'h0;
      for (int i = 0; i < 20; i++) begin
         ridx = 3'($urandom_range(0, 6));
         rd   = $urandom;
         rs   = 4'($urandom_range(0, 15));
         for (int b = 0; b < 4; b++) begin
            if (rs[b]) model[ridx][8*b +: 8] = rd[8*b +: 8];
         end
         xfer(0, 1, {ridx, 2'b00}, rd, rs, 3'b000, 32'h0, 1'b0);
         xfer(0, 0, {ridx, 2'b00}, $urandom, 4'($urandom_range(0, 15)), 3'b000,
              model[ridx], 1'b0);
      end

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
